mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Arbitrates the single unified instruction/data memory between two requesters: the multicycle CPU (fetch/load/store via the IorD-selected address) and a DMA/program-loader port.
- CPU has priority. The DMA side has a starvation guard and a lockable burst mode.
- Sits between the processor top and the memory instance. The control unit uses `cpu_stall` to hold its state when the CPU is not granted.

Parameters:
- WIDTH, 32, data word width
- ADDR_W, 32, address width
- MAX_WAIT, 8, cycles DMA may wait before it is forced to win one arbitration
- BURST_MAX, 16, maximum granted beats per locked DMA burst
- CNT_W, 5, counter width; must hold max(MAX_WAIT, BURST_MAX)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  WIDTH  CPU write data
- cpu_gnt  out  1  CPU granted this cycle (combinational)
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- cpu_rvalid  out  1  CPU read data valid (one-cycle pulse)
- cpu_rdata  out  WIDTH  registered CPU read data
- dma_req  in  1  DMA access request
- dma_we  in  1  DMA write/read
- dma_lock  in  1  DMA requests burst lock
- dma_addr  in  ADDR_W  DMA address
- dma_wdata  in  WIDTH  DMA write data
- dma_gnt  out  1  DMA granted this cycle (combinational)
- dma_rvalid  out  1  DMA read data valid pulse
- dma_rdata  out  WIDTH  registered DMA read data
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  WIDTH  memory write data
- mem_rdata  in  WIDTH  memory combinational read data

Behaviour:
- Reset (RST=0, asynchronous):
  - state=ARB; wait_cnt=0; beat_cnt=0; cpu_owed=0.
  - rvalids=0; rdata regs=0.
  - Any in-flight read return is dropped.
  - gnt outputs stay 0 while RST=0.
- Requester rule: hold req/we/addr/wdata stable until gnt=1 is seen in the same cycle. A granted request completes at that clock edge.
- At most one gnt per cycle; gnt=0 whenever the corresponding req=0.
- Memory mux:
  - Granted port drives mem_addr/mem_wdata; mem_we = granted port's we.
  - No grant: mem_we=0, mem_addr=0, mem_wdata=0.
- Read return:
  - A granted read captures mem_rdata into that port's rdata register at the edge.
  - That port's rvalid=1 for the following cycle only.
  - rdata holds its value until the next read by that port.
  - Writes produce no rvalid.
- States: ARB, DMA_LOCK (encoding in package).
- ARB priority:
  - (1) cpu_owed & cpu_req -> CPU.
  - (2) starve & dma_req -> DMA, where starve = (wait_cnt == MAX_WAIT).
  - (3) cpu_req -> CPU.
  - (4) dma_req -> DMA.
- ARB -> DMA_LOCK: DMA granted with dma_lock=1. beat_cnt is set to 1.
- DMA_LOCK:
  - dma_gnt = dma_req; cpu_gnt=0, even with cpu_req=1.
  - Each granted beat increments beat_cnt.
  - Exit to ARB when dma_lock=0 (sampled at the edge), or when a granted beat makes beat_cnt == BURST_MAX.
  - On a BURST_MAX exit, set cpu_owed=1.
- cpu_owed clears on the next CPU grant, or when cpu_req=0 in ARB.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) each cycle dma_req=1 and dma_gnt=0.
  - Clears on dma_gnt or when dma_req=0.
- Simultaneous requests with wait_cnt < MAX_WAIT -> CPU wins.
- dma_lock with no dma_gnt has no effect.
- Reset during DMA_LOCK returns to ARB; the burst is aborted.

Decomposition:
- Shared package: state encoding constants ARB/DMA_LOCK, and port-select constants SEL_NONE/SEL_CPU/SEL_DMA.
- Natural sub-module: none required. Optionally factor out arb_sat_counter (saturating counter with clear/inc/max flag), instanced for wait_cnt and beat_cnt.

Test Plan:
- CPU only: cpu_req=1, read addr 0x10 (mem holds 0xDEADBEEF) -> cpu_gnt=1 same cycle; next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF; dma_gnt=0.
- Contention: both req continuously, no lock, MAX_WAIT=8 -> CPU granted 8 cycles, DMA granted cycle 9, wait_cnt back to 0, pattern repeats; cpu_stall=1 exactly on DMA-grant cycles.
- Locked burst: dma_lock=1, dma_req=1 writing 0x100..0x10F while cpu_req=1 -> 16 consecutive DMA grants; cycle 17 cpu_gnt=1 (cpu_owed); all 16 words are in memory.
- Early unlock: dma_lock dropped after beat 3 -> state returns to ARB; next cycle CPU wins; cpu_owed stays 0.
- Reset mid-burst: assert RST=0 asynchronously at beat 5 -> gnt/rvalid go 0 immediately; after release, a CPU read is granted first cycle.
- Idle: no req -> mem_we=0, mem_addr=0, both rvalid=0 for 20 cycles.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared encodings for the unified-memory port arbiter:
//               arbiter FSM states and memory-port select codes.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

  // Arbiter FSM states
  localparam logic [0:0] ARB      = 1'b0;
  localparam logic [0:0] DMA_LOCK = 1'b1;

  // Which requester currently owns the memory port
  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_CPU  = 2'd1;
  localparam logic [1:0] SEL_DMA  = 2'd2;

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundle of the CPU port, DMA port and memory-side signals
//               around the arbiter. 'master' is the surrounding system
//               (CPU, DMA engine, memory); 'slave' is the arbiter itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32
);

  // CPU requester
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [WIDTH-1:0]  cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [WIDTH-1:0]  cpu_rdata;

  // DMA / program-loader requester
  logic              dma_req;
  logic              dma_we;
  logic              dma_lock;
  logic [ADDR_W-1:0] dma_addr;
  logic [WIDTH-1:0]  dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [WIDTH-1:0]  dma_rdata;

  // Memory instance
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  mem_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

endinterface : mem_port_arbiter_if
`default_nettype wire

// File: rtl/mem_port_arbiter_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : arb_sat_counter
// Description : Up-counter saturating at MAX_VAL, with clear and load.
//               Priority: clear > load > increment.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_sat_counter #(
  parameter int CNT_W   = 5,
  parameter int MAX_VAL = 8
) (
  input  wire logic             CLK,
  input  wire logic             RST,
  input  wire logic             clr,
  input  wire logic             ld,
  input  wire logic [CNT_W-1:0] ldVal,
  input  wire logic             inc,
  output logic      [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  // Count register: clear, load or saturating increment
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (ld) begin
      r_count <= ldVal;
    end else if (inc && (r_count != CNT_W'(MAX_VAL))) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule : arb_sat_counter
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares the unified instruction/data memory between the
//               multicycle CPU (priority) and a DMA/loader port. The DMA side
//               is protected from starvation and may lock bounded bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_WAIT  = 8,
  parameter int BURST_MAX = 16,
  parameter int CNT_W     = 5
) (
  input wire logic          CLK,
  input wire logic          RST,
  mem_port_arbiter_if.slave bus
);

  logic [0:0]       r_state;
  logic [0:0]       w_stateNext;
  logic             r_cpuOwed;
  logic             w_cpuOwedNext;
  logic [1:0]       w_sel;
  logic             w_cpuGnt;
  logic             w_dmaGnt;
  logic [CNT_W-1:0] w_waitCnt;
  logic [CNT_W-1:0] w_beatCnt;
  logic             w_starve;
  logic             w_beatLast;
  logic             w_beatLd;
  logic             w_beatInc;
  logic             w_beatClr;
  logic             w_waitClr;
  logic             w_waitInc;
  logic             r_cpuRvalid;
  logic [WIDTH-1:0] r_cpuRdata;
  logic             r_dmaRvalid;
  logic [WIDTH-1:0] r_dmaRdata;

  assign w_starve   = (w_waitCnt == CNT_W'(MAX_WAIT));
  // The beat being granted now is the last one allowed in this burst
  assign w_beatLast = (w_beatCnt == CNT_W'(BURST_MAX - 1));

  // Grant selection; reset low forces no grant without waiting for a clock
  always_comb begin
    w_sel = SEL_NONE;
    if (RST) begin
      if (r_state == DMA_LOCK) begin
        if (bus.dma_req) w_sel = SEL_DMA;
      end else if (r_cpuOwed && bus.cpu_req) begin
        w_sel = SEL_CPU;
      end else if (w_starve && bus.dma_req) begin
        w_sel = SEL_DMA;
      end else if (bus.cpu_req) begin
        w_sel = SEL_CPU;
      end else if (bus.dma_req) begin
        w_sel = SEL_DMA;
      end
    end
  end

  assign w_cpuGnt      = (w_sel == SEL_CPU);
  assign w_dmaGnt      = (w_sel == SEL_DMA);
  assign bus.cpu_gnt   = w_cpuGnt;
  assign bus.dma_gnt   = w_dmaGnt;
  assign bus.cpu_stall = bus.cpu_req & ~w_cpuGnt;

  // Memory port mux driven by the granted requester, quiet when idle
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (w_cpuGnt) begin
      bus.mem_we    = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (w_dmaGnt) begin
      bus.mem_we    = bus.dma_we;
      bus.mem_addr  = bus.dma_addr;
      bus.mem_wdata = bus.dma_wdata;
    end
  end

  // Next-state and CPU-owed bookkeeping
  always_comb begin
    w_stateNext   = r_state;
    w_cpuOwedNext = r_cpuOwed;
    case (r_state)
      ARB: begin
        if (w_dmaGnt && bus.dma_lock) w_stateNext = DMA_LOCK;
        if (w_cpuGnt || !bus.cpu_req) w_cpuOwedNext = 1'b0;
      end
      DMA_LOCK: begin
        if (!bus.dma_lock) begin
          w_stateNext = ARB;
        end else if (w_dmaGnt && w_beatLast) begin
          // Burst ran to its limit: the CPU gets the very next slot
          w_stateNext   = ARB;
          w_cpuOwedNext = 1'b1;
        end
      end
      default: w_stateNext = ARB;
    endcase
  end

  // FSM state and owed flag registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= ARB;
      r_cpuOwed <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_cpuOwed <= w_cpuOwedNext;
    end
  end

  // Starvation guard: counts cycles DMA is left waiting
  assign w_waitClr = w_dmaGnt | ~bus.dma_req;
  assign w_waitInc = bus.dma_req & ~w_dmaGnt;

  arb_sat_counter #(
    .CNT_W   (CNT_W),
    .MAX_VAL (MAX_WAIT)
  ) u_waitCnt (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (w_waitClr),
    .ld    (1'b0),
    .ldVal ('0),
    .inc   (w_waitInc),
    .count (w_waitCnt)
  );

  // Burst beat counter: first beat is granted from ARB, so it loads 1
  assign w_beatLd  = (r_state == ARB) & w_dmaGnt & bus.dma_lock;
  assign w_beatInc = (r_state == DMA_LOCK) & w_dmaGnt;
  assign w_beatClr = (r_state == ARB) & ~w_beatLd;

  arb_sat_counter #(
    .CNT_W   (CNT_W),
    .MAX_VAL (BURST_MAX)
  ) u_beatCnt (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (w_beatClr),
    .ld    (w_beatLd),
    .ldVal (CNT_W'(1)),
    .inc   (w_beatInc),
    .count (w_beatCnt)
  );

  // Read return: capture memory data for a granted read, pulse rvalid once
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cpuRvalid <= 1'b0;
      r_cpuRdata  <= '0;
      r_dmaRvalid <= 1'b0;
      r_dmaRdata  <= '0;
    end else begin
      r_cpuRvalid <= w_cpuGnt & ~bus.cpu_we;
      r_dmaRvalid <= w_dmaGnt & ~bus.dma_we;
      if (w_cpuGnt && !bus.cpu_we) r_cpuRdata <= bus.mem_rdata;
      if (w_dmaGnt && !bus.dma_we) r_dmaRdata <= bus.mem_rdata;
    end
  end

  assign bus.cpu_rvalid = r_cpuRvalid;
  assign bus.cpu_rdata  = r_cpuRdata;
  assign bus.dma_rvalid = r_dmaRvalid;
  assign bus.dma_rdata  = r_dmaRdata;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter with a
//               small word-addressed memory model behind the memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] memArr [0:511];

  mem_port_arbiter_if #(.WIDTH(32), .ADDR_W(32)) bus ();

  mem_port_arbiter #(
    .WIDTH(32), .ADDR_W(32), .MAX_WAIT(8), .BURST_MAX(16), .CNT_W(5)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Memory model: combinational read, synchronous write
  assign bus.mem_rdata = memArr[bus.mem_addr[8:0]];
  always @(posedge CLK) begin
    if (bus.mem_we) memArr[bus.mem_addr[8:0]] <= bus.mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) memArr[i] = 32'h0;
    memArr[16] = 32'hDEADBEEF;
    memArr[17] = 32'h11111111;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h10; bus.cpu_wdata = 32'h0;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_lock = 1'b0;
    bus.dma_addr = 32'h11; bus.dma_wdata = 32'h0;

    // Reset state: requests present but nothing granted while RST=0
    #12;
    check("rst_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
    check("rst_dma_gnt", 32'(bus.dma_gnt), 32'd0);
    check("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    check("rst_dma_rvalid", 32'(bus.dma_rvalid), 32'd0);
    check("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
    RST = 1'b1;
    tick();

    // CPU-only read of 0x10
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h10;
    #1;
    check("cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    check("cpu_dma_gnt", 32'(bus.dma_gnt), 32'd0);
    check("cpu_stall", 32'(bus.cpu_stall), 32'd0);
    check("cpu_mem_addr", bus.mem_addr, 32'h10);
    tick();
    bus.cpu_req = 1'b0;
    check("cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    check("cpu_rdata", bus.cpu_rdata, 32'hDEADBEEF);
    tick();
    check("cpu_rvalid_pulse", 32'(bus.cpu_rvalid), 32'd0);
    check("cpu_rdata_hold", bus.cpu_rdata, 32'hDEADBEEF);

    // Contention without lock: 8 CPU grants then one forced DMA grant
    bus.cpu_req = 1'b1; bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h11;
    for (int i = 0; i < 18; i++) begin
      #1;
      check($sformatf("cont_cpu_gnt_%0d", i), 32'(bus.cpu_gnt), (i % 9 == 8) ? 32'd0 : 32'd1);
      check($sformatf("cont_dma_gnt_%0d", i), 32'(bus.dma_gnt), (i % 9 == 8) ? 32'd1 : 32'd0);
      check($sformatf("cont_stall_%0d", i), 32'(bus.cpu_stall), (i % 9 == 8) ? 32'd1 : 32'd0);
      tick();
    end
    check("cont_dma_rvalid", 32'(bus.dma_rvalid), 32'd1);
    check("cont_dma_rdata", bus.dma_rdata, 32'h11111111);
    check("cont_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
    tick();

    // Locked write burst 0x100..0x10F; CPU requests from beat 2 on
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_lock = 1'b1;
    for (int b = 0; b < 16; b++) begin
      bus.dma_addr  = 32'h100 + 32'(b);
      bus.dma_wdata = 32'hA0000100 + 32'(b);
      #1;
      check($sformatf("burst_dma_gnt_%0d", b), 32'(bus.dma_gnt), 32'd1);
      check($sformatf("burst_cpu_gnt_%0d", b), 32'(bus.cpu_gnt), 32'd0);
      check($sformatf("burst_addr_%0d", b), bus.mem_addr, 32'h100 + 32'(b));
      tick();
      bus.cpu_req = 1'b1;
    end
    bus.dma_addr = 32'h110;
    #1;
    check("burst_owed_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    check("burst_owed_dma_gnt", 32'(bus.dma_gnt), 32'd0);
    tick();
    bus.cpu_req = 1'b0; bus.dma_req = 1'b0; bus.dma_lock = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) begin
      check($sformatf("burst_mem_%0d", k), memArr[256 + k], 32'hA0000100 + 32'(k));
    end

    // Early unlock after beat 3
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_lock = 1'b1; bus.dma_addr = 32'h120;
    #1;
    check("unlock_beat1", 32'(bus.dma_gnt), 32'd1);
    tick();
    bus.cpu_req = 1'b1;
    #1;
    check("unlock_beat2", 32'(bus.dma_gnt), 32'd1);
    check("unlock_beat2_cpu", 32'(bus.cpu_gnt), 32'd0);
    tick();
    bus.dma_lock = 1'b0;
    #1;
    check("unlock_beat3", 32'(bus.dma_gnt), 32'd1);
    tick();
    #1;
    check("unlock_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    check("unlock_dma_gnt", 32'(bus.dma_gnt), 32'd0);
    tick();
    bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
    tick();

    // Reset in the middle of a locked read burst, at beat 5
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_lock = 1'b1; bus.dma_addr = 32'h100;
    tick();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h10;
    tick(); tick(); tick();
    #1;
    check("rstb_beat5_gnt", 32'(bus.dma_gnt), 32'd1);
    check("rstb_beat4_rvalid", 32'(bus.dma_rvalid), 32'd1);
    RST = 1'b0;
    #1;
    check("rstb_dma_gnt", 32'(bus.dma_gnt), 32'd0);
    check("rstb_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
    check("rstb_dma_rvalid", 32'(bus.dma_rvalid), 32'd0);
    check("rstb_dma_rdata", bus.dma_rdata, 32'd0);
    tick();
    RST = 1'b1;
    #1;
    check("rstb_cpu_first", 32'(bus.cpu_gnt), 32'd1);
    check("rstb_dma_after", 32'(bus.dma_gnt), 32'd0);
    tick();
    bus.cpu_req = 1'b0; bus.dma_req = 1'b0; bus.dma_lock = 1'b0;
    check("rstb_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    check("rstb_cpu_rdata", bus.cpu_rdata, 32'hDEADBEEF);
    tick();

    // Idle: memory port quiet, no read returns
    for (int i = 0; i < 20; i++) begin
      check($sformatf("idle_we_%0d", i), 32'(bus.mem_we), 32'd0);
      check($sformatf("idle_addr_%0d", i), bus.mem_addr, 32'd0);
      check($sformatf("idle_wdata_%0d", i), bus.mem_wdata, 32'd0);
      check($sformatf("idle_crv_%0d", i), 32'(bus.cpu_rvalid), 32'd0);
      check($sformatf("idle_drv_%0d", i), 32'(bus.dma_rvalid), 32'd0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire
